// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Optional macro DMEM_ERR_EN adds resp_err_o for misaligned or out-of-range accesses.
module dmem_responder #(
    parameter int unsigned DMEM_DEPTH      = 1024,
    parameter int unsigned DMEM_ADDR_WIDTH = 10,
    parameter int unsigned LATENCY         = 2
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_rdata_o,
`ifdef DMEM_ERR_EN
    output logic        resp_err_o,
`endif
    output logic        resp_write_o
);

    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e                       state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic [DMEM_ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                         write_q, write_d;
    logic                         err_q, err_d;
    logic [63:0]                  rdata_q, rdata_d;

    logic [63:0]                  mem_q [DMEM_DEPTH];
    logic [DMEM_ADDR_WIDTH-1:0]   req_idx;
    logic                         acc_err;
    logic                         mem_we;

    assign req_idx = req_addr_i[DMEM_ADDR_WIDTH+2:3];

`ifdef DMEM_ERR_EN
    assign acc_err = (req_addr_i[2:0] != 3'b000) || (|req_addr_i[63:DMEM_ADDR_WIDTH+3]);
`else
    // Byte offset and high bits are intentionally dropped in the default build.
    logic unused_addr;
    assign unused_addr = ^{req_addr_i[63:DMEM_ADDR_WIDTH+3], req_addr_i[2:0]};
    assign acc_err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    idx_d   = req_idx;
                    write_d = req_write_i;
                    err_d   = acc_err;
                    cnt_d   = CntInit;
                    // Stores commit at acceptance so a following load sees them.
                    mem_we  = req_write_i && !acc_err;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = (write_q || err_q) ? 64'd0 : mem_q[idx_q];
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[req_idx] <= req_wdata_i;
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = (state_q == StResp);
    assign resp_rdata_o = rdata_q;
    assign resp_write_o = write_q;
`ifdef DMEM_ERR_EN
    assign resp_err_o   = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 LATENCY=2, 1 LATENCY=1, 2 LATENCY=15.
module tb_dmem_responder;

    logic        clk;
    logic        reset_b;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [63:0] req_addr   [3];
    logic [63:0] req_wdata  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [63:0] resp_rdata [3];
    logic        resp_write [3];
`ifdef DMEM_ERR_EN
    logic        resp_err   [3];
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat_g;
    logic [63:0] rd_g;
    logic        rw_g;
    logic        err_g;
    time         acc_t_g;
    time         t_first;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        dmem_responder #(
            .DMEM_DEPTH     (1024),
            .DMEM_ADDR_WIDTH(10),
            .LATENCY        (Lat)
        ) u_dut (
            .clk         (clk),
            .reset_b     (reset_b),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_write_i (req_write[g]),
            .req_addr_i  (req_addr[g]),
            .req_wdata_i (req_wdata[g]),
            .resp_valid_o(resp_valid[g]),
            .resp_ready_i(resp_ready[g]),
            .resp_rdata_o(resp_rdata[g]),
`ifdef DMEM_ERR_EN
            .resp_err_o  (resp_err[g]),
`endif
            .resp_write_o(resp_write[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge; returns #1 after the response handshake edge.
    task automatic xact(input int u, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wd);
        int n;
        req_valid[u] = 1'b1;
        req_write[u] = wr;
        req_addr[u]  = addr;
        req_wdata[u] = wd;
        n = 0;
        while (!req_ready[u] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk);
        acc_t_g = $time;
        #1;
        req_valid[u] = 1'b0;
        lat_g = 0;
        while (!resp_valid[u] && lat_g < 40) begin
            @(posedge clk); #1;
            lat_g++;
        end
        rd_g = resp_rdata[u];
        rw_g = resp_write[u];
`ifdef DMEM_ERR_EN
        err_g = resp_err[u];
`else
        err_g = 1'b0;
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        reset_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i]  = 1'b0;
            req_write[i]  = 1'b0;
            req_addr[i]   = 64'd0;
            req_wdata[i]  = 64'd0;
            resp_ready[i] = 1'b1;
        end
        #2;
        chk("rst_req_ready", 64'(req_ready[0]), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
        chk("rst_resp_rdata", resp_rdata[0], 64'd0);
        chk("rst_resp_write", 64'(resp_write[0]), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_b = 1'b1;
        @(posedge clk); #1;

        // Store then load, LATENCY=2
        xact(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D);
        chk("st_lat", 64'(lat_g), 64'd2);
        chk("st_rdata", rd_g, 64'd0);
        chk("st_write", 64'(rw_g), 64'd1);
        xact(0, 1'b0, 64'h10, 64'd0);
        chk("ld_lat", 64'(lat_g), 64'd2);
        chk("ld_rdata", rd_g, 64'hDEADBEEF_CAFEF00D);
        chk("ld_write", 64'(rw_g), 64'd0);

        // Backpressure: response held while a second request waits
        resp_ready[0] = 1'b0;
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b0;
        req_addr[0]   = 64'h10;
        @(posedge clk); #1;
        chk("bp_acc_ready", 64'(req_ready[0]), 64'd0);
        @(posedge clk); #1;
        chk("bp_e1_valid", 64'(resp_valid[0]), 64'd0);
        @(posedge clk); #1;
        chk("bp_valid", 64'(resp_valid[0]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(resp_valid[0]), 64'd1);
            chk("bp_hold_rdata", resp_rdata[0], 64'hDEADBEEF_CAFEF00D);
            chk("bp_hold_ready", 64'(req_ready[0]), 64'd0);
        end
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_valid", 64'(resp_valid[0]), 64'd0);
        chk("bp_hs_ready", 64'(req_ready[0]), 64'd1);
        @(posedge clk); #1;
        chk("bp_second_acc", 64'(req_ready[0]), 64'd0);
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("bp2_e1_valid", 64'(resp_valid[0]), 64'd0);
        @(posedge clk); #1;
        chk("bp2_valid", 64'(resp_valid[0]), 64'd1);
        chk("bp2_rdata", resp_rdata[0], 64'hDEADBEEF_CAFEF00D);
        @(posedge clk); #1;

        // Latency sweep: LATENCY=1
        xact(1, 1'b1, 64'h8, 64'h0123_4567_89AB_CDEF);
        t_first = acc_t_g;
        chk("l1_st_lat", 64'(lat_g), 64'd1);
        xact(1, 1'b0, 64'h8, 64'd0);
        chk("l1_ld_lat", 64'(lat_g), 64'd1);
        chk("l1_ld_rdata", rd_g, 64'h0123_4567_89AB_CDEF);
        chk("l1_spacing", 64'((acc_t_g - t_first) / 10), 64'd3);

        // Latency sweep: LATENCY=15
        xact(2, 1'b1, 64'h18, 64'hA5A5_0000_5A5A_FFFF);
        t_first = acc_t_g;
        chk("l15_st_lat", 64'(lat_g), 64'd15);
        xact(2, 1'b0, 64'h18, 64'd0);
        chk("l15_ld_lat", 64'(lat_g), 64'd15);
        chk("l15_ld_rdata", rd_g, 64'hA5A5_0000_5A5A_FFFF);
        chk("l15_spacing", 64'((acc_t_g - t_first) / 10), 64'd17);

        // Reset during WAIT drops the response but keeps the store
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 64'h20;
        req_wdata[0] = 64'h1234;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk("rw_in_wait", 64'(req_ready[0]), 64'd0);
        #2;
        reset_b = 1'b0;
        #1;
        chk("rw_rst_ready", 64'(req_ready[0]), 64'd1);
        chk("rw_rst_write", 64'(resp_write[0]), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rw_no_resp", 64'(resp_valid[0]), 64'd0);
        end
        xact(0, 1'b0, 64'h20, 64'd0);
        chk("rw_ld_rdata", rd_g, 64'h1234);
        chk("rw_ld_lat", 64'(lat_g), 64'd2);

`ifndef DMEM_ERR_EN
        // Offset and high bits are ignored: 0x2007 maps to word 0
        xact(0, 1'b1, 64'h2007, 64'h55);
        chk("tr_st_write", 64'(rw_g), 64'd1);
        xact(0, 1'b0, 64'h0, 64'd0);
        chk("tr_ld_rdata", rd_g, 64'h55);
`else
        xact(0, 1'b1, 64'h0, 64'h77);
        chk("er_ok_st_err", 64'(err_g), 64'd0);
        xact(0, 1'b0, 64'hC, 64'd0);
        chk("er_mis_err", 64'(err_g), 64'd1);
        chk("er_mis_rdata", rd_g, 64'd0);
        chk("er_mis_lat", 64'(lat_g), 64'd2);
        xact(0, 1'b1, 64'h2000, 64'h99);
        chk("er_oor_err", 64'(err_g), 64'd1);
        xact(0, 1'b0, 64'h0, 64'd0);
        chk("er_ok_ld_err", 64'(err_g), 64'd0);
        chk("er_ok_ld_rdata", rd_g, 64'h77);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
